lru_refill_controller: RTL and testbench
========================================

// Module: lru_refill_controller
// PURPOSE
//  Miss/refill sequencer for the 4-way cache. Accepts one lookup at a time, reads the tag
//  compare result, updates the matrix LRU (drives its one-hot access input and reads its
//  per-way row-OR output), picks a victim on miss, fetches the line from memory, and
//  streams the beats into the data array. Sits between the CPU port and tag/data/LRU arrays.
// PARAMETERS
//  WAYS        4    ways per set; one-hot vectors are WAYS wide (RTL supports 4 only)
//  ADDR_W      16   byte/word address width of req_addr and mem_addr
//  LINE_WORDS  4    beats per line refill; power of 2, >=2; BEAT_W = $clog2(LINE_WORDS)
// PORTS
//  clk         in   1        single clock, all state on rising edge
//  reset       in   1        asynchronous, active-high; clears all state
//  req_valid   in   1        lookup request
//  req_ready   out  1        high only in IDLE with inv_all low
//  req_addr    in   ADDR_W   lookup address, captured on accept
//  hit_way     in   WAYS     tag compare for captured addr, one-hot; 0 = miss
//  lru_rows    in   WAYS     LRU matrix output; bit i = 0 -> way i is least recent
//  lru_touch   out  WAYS     one-hot, 1-cycle pulse: mark way most-recently-used
//  inv_all     in   1        clear all way-valid bits
//  mem_req     out  1        refill request, held until mem_ack
//  mem_addr    out  ADDR_W   line-aligned address (low BEAT_W bits zero)
//  mem_ack     in   1        memory accepted request
//  mem_beat    in   1        one refill beat present this cycle
//  fill_we     out  1        write current beat into data array
//  fill_way    out  WAYS     one-hot victim way for fill_we
//  fill_beat   out  BEAT_W   beat index for fill_we
//  resp_valid  out  1        1-cycle completion pulse
//  resp_hit    out  1        1 = hit, 0 = filled after miss
//  resp_way    out  WAYS     one-hot way holding the line
//  err_multi   out  1        sticky: hit_way had >1 bit set
// BEHAVIOUR
//  Reset: state IDLE, valid[]=0, beat counter 0, err_multi 0, every output 0 except
//   req_ready (1 once reset deasserts and inv_all is low).
//  States: IDLE, LOOKUP, REFILL_REQ, REFILL_DATA, FILL_DONE.
//  IDLE: inv_all high -> valid[]<=0, req_ready=0, request not accepted (inv_all wins).
//   Else req_valid -> capture req_addr, go LOOKUP.
//  LOOKUP (exactly 1 cycle): hit_way!=0 -> same cycle lru_touch=hit_way, resp_valid=1,
//   resp_hit=1, resp_way=hit_way; -> IDLE. Hit latency: accept + 1 cycle.
//   >1 bit set: use lowest-index set bit for touch/resp, set err_multi.
//   hit_way==0 -> register victim, -> REFILL_REQ.
//  Victim: lowest-index way with valid=0; else lowest-index i with lru_rows[i]=0;
//   else (all rows 1, illegal matrix) way 0.
//  REFILL_REQ: mem_req=1, mem_addr={addr[ADDR_W-1:BEAT_W],0}; stable until mem_ack
//   sampled high, then -> REFILL_DATA, counter 0. mem_beat in this state ignored.
//  REFILL_DATA: each cycle with mem_beat: fill_we=1, fill_way=victim, fill_beat=counter,
//   counter++; beat LINE_WORDS-1 -> FILL_DONE. Gaps (mem_beat=0) allowed, no timeout.
//  FILL_DONE (1 cycle): lru_touch=victim, valid[victim]<=1, resp_valid=1, resp_hit=0,
//   resp_way=victim; -> IDLE. Outputs not named for a state are 0 in that state.
//  inv_all outside IDLE ignored. err_multi cleared only by reset.
//  Reset mid-refill: abort immediately; mem_req/fill_we drop asynchronously, no resp.
// STRUCTURE
//  cache_pkg (shared include): state encodings, WAYS, LINE_WORDS, BEAT_W, onehot-to-lowest
//   priority function (reused by tag and LRU logic).
//  One sub-module: victim_select (combinational: valid[], lru_rows -> one-hot victim).
//  FSM, valid register, beat counter and address register stay in this module.
// TESTING
//  Hit: reset, req addr 0x0040, hit_way=0010 -> resp_valid 1 cycle after accept,
//   resp_hit=1, resp_way=0010, lru_touch=0010 same cycle, no mem_req.
//  Cold misses: after reset, 4 misses -> victims 0001,0010,0100,1000 in order; each
//   mem_addr line-aligned (req 0x0123 -> 0x0120); 4 fill_we beats 0..3; valid=1111.
//  LRU victim: all valid, lru_rows=1011 -> victim 0100; lru_rows=1111 -> victim 0001.
//  Handshake: mem_ack held low 5 cycles -> mem_req/mem_addr stable; beats with gaps
//   (1,0,1,1,0,1) -> exactly 4 fill_we, FILL_DONE one cycle after last beat.
//  inv_all + req_valid same cycle in IDLE -> req not accepted, valid=0000; next miss
//   victim 0001. inv_all during refill -> ignored, valid[victim] set at FILL_DONE.
//  Reset asserted in REFILL_DATA after beat 1 -> mem_req/fill_we/resp 0 at once, IDLE,
//   valid=0000; hit_way=0110 -> err_multi=1, resp_way=0010.

Source files
------------

// File: rtl/lru_refill_controller_pkg.sv
// Shared types, sizes and helpers for the 4-way cache miss/refill sequencer.
package lru_refill_controller_pkg;

  localparam int unsigned WAYS       = 4;
  localparam int unsigned ADDR_W     = 16;
  localparam int unsigned LINE_WORDS = 4;
  localparam int unsigned BEAT_W     = $clog2(LINE_WORDS);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_LOOKUP      = 3'd1,
    S_REFILL_REQ  = 3'd2,
    S_REFILL_DATA = 3'd3,
    S_FILL_DONE   = 3'd4
  } state_t;

  // Isolate the lowest set bit; zero in gives zero out.
  function automatic logic [WAYS-1:0] lowest_set(input logic [WAYS-1:0] v);
    return v & (~v + WAYS'(1));
  endfunction

  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] a);
    return a & ~ADDR_W'(LINE_WORDS - 1);
  endfunction

endpackage

// File: rtl/lru_refill_controller_if.sv
// CPU lookup, tag/LRU array, memory and data-array fill signals of the refill controller.
interface lru_refill_controller_if;
  import lru_refill_controller_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [WAYS-1:0]   hit_way;
  logic [WAYS-1:0]   lru_rows;
  logic [WAYS-1:0]   lru_touch;
  logic              inv_all;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic              mem_beat;
  logic              fill_we;
  logic [WAYS-1:0]   fill_way;
  logic [BEAT_W-1:0] fill_beat;
  logic              resp_valid;
  logic              resp_hit;
  logic [WAYS-1:0]   resp_way;
  logic              err_multi;

  // Environment side: CPU port, tag/LRU arrays and memory.
  modport master (
    output req_valid, req_addr, hit_way, lru_rows, inv_all, mem_ack, mem_beat,
    input  req_ready, lru_touch, mem_req, mem_addr, fill_we, fill_way, fill_beat,
           resp_valid, resp_hit, resp_way, err_multi
  );

  // Controller side.
  modport slave (
    input  req_valid, req_addr, hit_way, lru_rows, inv_all, mem_ack, mem_beat,
    output req_ready, lru_touch, mem_req, mem_addr, fill_we, fill_way, fill_beat,
           resp_valid, resp_hit, resp_way, err_multi
  );

endinterface

// File: rtl/lru_refill_controller_victim_select.sv
// Victim choice: first invalid way, else first least-recent way, else way 0.
module lru_refill_controller_victim_select
  import lru_refill_controller_pkg::*;
(
  input  logic [WAYS-1:0] valid,
  input  logic [WAYS-1:0] lru_rows,
  output logic [WAYS-1:0] victim_c
);

  logic [WAYS-1:0] free_c;
  logic [WAYS-1:0] old_c;

  assign free_c = ~valid;
  assign old_c  = ~lru_rows;

  // An all-ones row set is an illegal matrix; fall back to way 0.
  always_comb begin
    victim_c = WAYS'(1);
    if (free_c != '0) begin
      victim_c = lowest_set(free_c);
    end else if (old_c != '0) begin
      victim_c = lowest_set(old_c);
    end
  end

endmodule

// File: rtl/lru_refill_controller.sv
// Miss/refill sequencer for the 4-way cache: lookup, LRU touch, victim refill, response.
module lru_refill_controller
  import lru_refill_controller_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  lru_refill_controller_if.slave bus
);

  state_t            state_q, state_d;
  logic [WAYS-1:0]   valid_q, valid_d;
  logic [WAYS-1:0]   victim_q, victim_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              err_multi_q, err_multi_d;

  logic [WAYS-1:0]   victim_c;
  logic [WAYS-1:0]   hit_first_c;
  logic              hit_multi_c;

  lru_refill_controller_victim_select u_victim_select (
    .valid    (valid_q),
    .lru_rows (bus.lru_rows),
    .victim_c (victim_c)
  );

  assign hit_first_c   = lowest_set(bus.hit_way);
  assign hit_multi_c   = (bus.hit_way & (bus.hit_way - WAYS'(1))) != '0;
  assign bus.err_multi = err_multi_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      valid_q     <= '0;
      victim_q    <= '0;
      addr_q      <= '0;
      beat_q      <= '0;
      err_multi_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      victim_q    <= victim_d;
      addr_q      <= addr_d;
      beat_q      <= beat_d;
      err_multi_q <= err_multi_d;
    end
  end

  // Outputs decode from state so reset drops them without waiting for a clock.
  always_comb begin
    state_d        = state_q;
    valid_d        = valid_q;
    victim_d       = victim_q;
    addr_d         = addr_q;
    beat_d         = beat_q;
    err_multi_d    = err_multi_q;
    bus.req_ready  = 1'b0;
    bus.lru_touch  = '0;
    bus.mem_req    = 1'b0;
    bus.mem_addr   = '0;
    bus.fill_we    = 1'b0;
    bus.fill_way   = '0;
    bus.fill_beat  = '0;
    bus.resp_valid = 1'b0;
    bus.resp_hit   = 1'b0;
    bus.resp_way   = '0;

    case (state_q)
      S_IDLE: begin
        if (bus.inv_all) begin
          valid_d = '0;
        end else begin
          bus.req_ready = !reset;
          if (bus.req_valid) begin
            addr_d  = bus.req_addr;
            state_d = S_LOOKUP;
          end
        end
      end

      S_LOOKUP: begin
        if (bus.hit_way != '0) begin
          bus.lru_touch  = hit_first_c;
          bus.resp_valid = 1'b1;
          bus.resp_hit   = 1'b1;
          bus.resp_way   = hit_first_c;
          if (hit_multi_c) begin
            err_multi_d = 1'b1;
          end
          state_d = S_IDLE;
        end else begin
          victim_d = victim_c;
          state_d  = S_REFILL_REQ;
        end
      end

      S_REFILL_REQ: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = line_align(addr_q);
        if (bus.mem_ack) begin
          beat_d  = '0;
          state_d = S_REFILL_DATA;
        end
      end

      S_REFILL_DATA: begin
        if (bus.mem_beat) begin
          bus.fill_we   = 1'b1;
          bus.fill_way  = victim_q;
          bus.fill_beat = beat_q;
          beat_d        = beat_q + BEAT_W'(1);
          if (beat_q == BEAT_W'(LINE_WORDS - 1)) begin
            state_d = S_FILL_DONE;
          end
        end
      end

      S_FILL_DONE: begin
        bus.lru_touch  = victim_q;
        bus.resp_valid = 1'b1;
        bus.resp_way   = victim_q;
        valid_d        = valid_q | victim_q;
        state_d        = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_lru_refill_controller.sv
// Self-checking bench for lru_refill_controller: directed table, corner sequences, random vs model.
module tb_lru_refill_controller;

  logic clk;
  logic reset;

  lru_refill_controller_if bus ();

  lru_refill_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors;
  int checks;

  typedef struct {
    logic        ready;
    logic        lookup_resp;
    logic        mreq_at_lookup;
    logic        hit;
    logic [3:0]  way;
    logic [3:0]  touch;
    logic [15:0] maddr;
    logic        maddr_stable;
    int          req_cycles;
    logic [3:0]  fway;
    logic        order_ok;
    int          beats;
    int          stray;
    int          done_gap;
    logic        timeout;
    logic        resp_after;
    logic        err_after;
  } obs_t;

  typedef struct {
    logic [15:0] addr;
    logic [3:0]  hw;
    logic [3:0]  rows;
    logic        exp_hit;
    logic [3:0]  exp_way;
    logic [15:0] exp_maddr;
    logic        exp_err;
  } vec_t;

  // Reference state: which ways hold lines, and the sticky multi-hit flag.
  logic [3:0] m_valid;
  logic       m_err;

  obs_t o;
  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] m_lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++) begin
      if (v[i]) return 4'b0001 << i;
    end
    return 4'b0000;
  endfunction

  function automatic logic [3:0] m_victim(input logic [3:0] v, input logic [3:0] rows);
    for (int i = 0; i < 4; i++) begin
      if (!v[i]) return 4'b0001 << i;
    end
    for (int i = 0; i < 4; i++) begin
      if (!rows[i]) return 4'b0001 << i;
    end
    return 4'b0001;
  endfunction

  // Predict one lookup and advance the model.
  task automatic model_txn(input logic [3:0] hw, input logic [3:0] rows, input logic [15:0] addr,
                           output logic hit, output logic [3:0] way, output logic [15:0] maddr);
    maddr = {addr[15:2], 2'b00};
    if (hw != 4'b0000) begin
      hit = 1'b1;
      way = m_lowest(hw);
      if ($countones(hw) > 1) m_err = 1'b1;
    end else begin
      hit = 1'b0;
      way = m_victim(m_valid, rows);
      m_valid = m_valid | way;
    end
  endtask

  task automatic run_txn(input logic [15:0] addr, input logic [3:0] hw, input logic [3:0] rows,
                         input int ack_dly, input logic use_pat, input logic [15:0] pat,
                         input logic inv_mid, output obs_t r);
    int   cyc;
    int   last;
    bit   done;
    logic mb;
    r = '{default: 0};
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_addr = addr; bus.hit_way = hw; bus.lru_rows = rows;
    bus.inv_all = 1'b0; bus.mem_ack = 1'b0; bus.mem_beat = 1'b0;
    #1 r.ready = bus.req_ready;
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.req_addr = 16'($urandom);
    #1;
    r.lookup_resp    = bus.resp_valid;
    r.mreq_at_lookup = bus.mem_req;
    if (bus.resp_valid) begin
      r.hit = bus.resp_hit; r.way = bus.resp_way; r.touch = bus.lru_touch;
    end else begin
      r.maddr_stable = 1'b1;
      for (int k = 0; k <= ack_dly; k++) begin
        @(posedge clk); #1;
        bus.mem_ack = (k == ack_dly); bus.mem_beat = 1'b1; bus.inv_all = inv_mid;
        #1;
        if (k == 0) r.maddr = bus.mem_addr;
        else if (bus.mem_addr !== r.maddr) r.maddr_stable = 1'b0;
        if (bus.mem_req !== 1'b1) r.maddr_stable = 1'b0;
        if (bus.fill_we !== 1'b0 || bus.resp_valid !== 1'b0) r.stray++;
        r.req_cycles++;
      end
      cyc = 0; last = -1; done = 0; r.order_ok = 1'b1;
      while (!done && cyc < 200) begin
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        mb = use_pat ? ((cyc < 16) ? pat[cyc] : 1'b1) : 1'($urandom_range(0, 1));
        bus.mem_beat = mb;
        #1;
        if (bus.resp_valid === 1'b1) begin
          r.hit = bus.resp_hit; r.way = bus.resp_way; r.touch = bus.lru_touch;
          r.done_gap = cyc - last;
          done = 1;
        end else begin
          if (bus.mem_req !== 1'b0) r.stray++;
          if (bus.fill_we !== mb) r.stray++;
          if (bus.fill_we === 1'b1) begin
            if (bus.fill_beat !== 2'(r.beats)) r.order_ok = 1'b0;
            if (r.beats == 0) r.fway = bus.fill_way;
            else if (bus.fill_way !== r.fway) r.order_ok = 1'b0;
            r.beats++;
            last = cyc;
          end
        end
        cyc++;
      end
      if (!done) r.timeout = 1'b1;
      bus.inv_all = 1'b0; bus.mem_beat = 1'b0;
    end
    @(posedge clk); #2;
    r.resp_after = bus.resp_valid;
    r.err_after  = bus.err_multi;
  endtask

  task automatic eval(input string tag, input obs_t r, input logic eh, input logic [3:0] ew,
                      input logic [15:0] em, input logic ee);
    chk({tag, "_ready"}, r.ready, 1);
    chk({tag, "_lookup_resp"}, r.lookup_resp, eh);
    chk({tag, "_mreq_lookup"}, r.mreq_at_lookup, 0);
    chk({tag, "_resp_hit"}, r.hit, eh);
    chk({tag, "_resp_way"}, r.way, ew);
    chk({tag, "_touch"}, r.touch, ew);
    if (!eh) begin
      chk({tag, "_mem_addr"}, r.maddr, em);
      chk({tag, "_mem_stable"}, r.maddr_stable, 1);
      chk({tag, "_beats"}, r.beats, 4);
      chk({tag, "_beat_order"}, r.order_ok, 1);
      chk({tag, "_fill_way"}, r.fway, ew);
      chk({tag, "_stray"}, r.stray, 0);
      chk({tag, "_done_gap"}, r.done_gap, 1);
      chk({tag, "_timeout"}, r.timeout, 0);
    end
    chk({tag, "_resp_pulse"}, r.resp_after, 0);
    chk({tag, "_err_multi"}, r.err_after, ee);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        eh;
    logic [3:0]  ew;
    logic [15:0] em;
    logic [3:0]  hw;
    errors = 0; checks = 0;
    clk = 1'b0; reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.hit_way = '0; bus.lru_rows = '0;
    bus.inv_all = 1'b0; bus.mem_ack = 1'b0; bus.mem_beat = 1'b0;
    m_valid = 4'b0000; m_err = 1'b0;

    tbl[0] = '{16'h0040, 4'b0010, 4'b0000, 1'b1, 4'b0010, 16'h0000, 1'b0};
    tbl[1] = '{16'h0123, 4'b0000, 4'b0000, 1'b0, 4'b0001, 16'h0120, 1'b0};
    tbl[2] = '{16'h0200, 4'b0000, 4'b1111, 1'b0, 4'b0010, 16'h0200, 1'b0};
    tbl[3] = '{16'h0337, 4'b0000, 4'b0000, 1'b0, 4'b0100, 16'h0334, 1'b0};
    tbl[4] = '{16'h0FFF, 4'b0000, 4'b0000, 1'b0, 4'b1000, 16'h0FFC, 1'b0};
    tbl[5] = '{16'h1235, 4'b0000, 4'b1011, 1'b0, 4'b0100, 16'h1234, 1'b0};
    tbl[6] = '{16'hABCD, 4'b0000, 4'b1111, 1'b0, 4'b0001, 16'hABCC, 1'b0};
    tbl[7] = '{16'h7002, 4'b0000, 4'b0111, 1'b0, 4'b1000, 16'h7000, 1'b0};
    tbl[8] = '{16'h0044, 4'b1000, 4'b0000, 1'b1, 4'b1000, 16'h0000, 1'b0};

    // Reset state.
    #12;
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_fill_we", bus.fill_we, 0);
    chk("rst_resp_valid", bus.resp_valid, 0);
    @(posedge clk); #1 reset = 1'b0; #1;
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_err_multi", bus.err_multi, 0);
    chk("rst_lru_touch", bus.lru_touch, 0);

    // Directed table: hit, cold misses, LRU-driven victims.
    for (int i = 0; i < 9; i++) begin
      run_txn(tbl[i].addr, tbl[i].hw, tbl[i].rows, 0, 1'b1, 16'hFFFF, 1'b0, o);
      model_txn(tbl[i].hw, tbl[i].rows, tbl[i].addr, eh, ew, em);
      eval($sformatf("tbl%0d", i), o, tbl[i].exp_hit, tbl[i].exp_way, tbl[i].exp_maddr,
           tbl[i].exp_err);
    end

    // Slow ack and gapped beats 1,0,1,1,0,1.
    run_txn(16'h2468, 4'b0000, 4'b1101, 5, 1'b1, 16'b0000_0000_0010_1101, 1'b0, o);
    model_txn(4'b0000, 4'b1101, 16'h2468, eh, ew, em);
    eval("handshake", o, 1'b0, 4'b0010, 16'h2468, 1'b0);
    chk("handshake_req_cycles", o.req_cycles, 6);

    // inv_all beats a simultaneous request in IDLE.
    @(posedge clk); #1;
    bus.inv_all = 1'b1; bus.req_valid = 1'b1; bus.req_addr = 16'h3000; bus.hit_way = 4'b0001;
    #1 chk("inv_req_ready", bus.req_ready, 0);
    @(posedge clk); #1;
    bus.inv_all = 1'b0; bus.req_valid = 1'b0;
    #1;
    chk("inv_no_accept_resp", bus.resp_valid, 0);
    chk("inv_no_accept_mreq", bus.mem_req, 0);
    m_valid = 4'b0000;
    run_txn(16'h3005, 4'b0000, 4'b0111, 1, 1'b1, 16'hFFFF, 1'b0, o);
    model_txn(4'b0000, 4'b0111, 16'h3005, eh, ew, em);
    eval("inv_victim", o, 1'b0, 4'b0001, 16'h3004, 1'b0);

    // inv_all while refilling is ignored; the victim still becomes valid.
    run_txn(16'h3104, 4'b0000, 4'b0000, 2, 1'b1, 16'hFFFF, 1'b1, o);
    model_txn(4'b0000, 4'b0000, 16'h3104, eh, ew, em);
    eval("inv_mid", o, 1'b0, 4'b0010, 16'h3104, 1'b0);
    run_txn(16'h3208, 4'b0000, 4'b0000, 0, 1'b1, 16'hFFFF, 1'b0, o);
    model_txn(4'b0000, 4'b0000, 16'h3208, eh, ew, em);
    eval("inv_mid_after", o, 1'b0, 4'b0100, 16'h3208, 1'b0);

    // Reset during the data phase after two beats.
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_addr = 16'h5550; bus.hit_way = 4'b0000; bus.lru_rows = 4'b0000;
    @(posedge clk); #1 bus.req_valid = 1'b0;
    @(posedge clk); #1 bus.mem_ack = 1'b1;
    #1 chk("rstmid_mem_req", bus.mem_req, 1);
    @(posedge clk); #1 bus.mem_ack = 1'b0; bus.mem_beat = 1'b1;
    @(posedge clk);
    @(posedge clk); #2;
    chk("rstmid_fill_we_before", bus.fill_we, 1);
    chk("rstmid_fill_beat_before", bus.fill_beat, 2);
    #1 reset = 1'b1;
    #1;
    chk("rstmid_fill_we", bus.fill_we, 0);
    chk("rstmid_mem_req_drop", bus.mem_req, 0);
    chk("rstmid_resp", bus.resp_valid, 0);
    chk("rstmid_touch", bus.lru_touch, 0);
    bus.mem_beat = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    m_valid = 4'b0000; m_err = 1'b0;

    // Multi-bit hit after reset: lowest way answers, error is sticky.
    run_txn(16'h0040, 4'b0110, 4'b0000, 0, 1'b1, 16'hFFFF, 1'b0, o);
    model_txn(4'b0110, 4'b0000, 16'h0040, eh, ew, em);
    eval("multi_hit", o, 1'b1, 4'b0010, 16'h0000, 1'b1);
    run_txn(16'h0ACE, 4'b0000, 4'b0111, 0, 1'b1, 16'hFFFF, 1'b0, o);
    model_txn(4'b0000, 4'b0111, 16'h0ACE, eh, ew, em);
    eval("post_reset_victim", o, 1'b0, 4'b0001, 16'h0ACC, 1'b1);

    // Random traffic against the model.
    for (int n = 0; n < 60; n++) begin
      logic [15:0] a;
      logic [3:0]  rows;
      a    = 16'($urandom);
      rows = 4'($urandom_range(0, 15));
      hw   = ($urandom_range(0, 3) < 2) ? 4'b0000 : 4'($urandom_range(1, 15));
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk); #1 bus.inv_all = 1'b1; bus.req_valid = 1'b0;
        @(posedge clk); #1 bus.inv_all = 1'b0;
        m_valid = 4'b0000;
      end
      run_txn(a, hw, rows, int'($urandom_range(0, 3)), 1'b0, 16'h0000,
              1'($urandom_range(0, 1)), o);
      model_txn(hw, rows, a, eh, ew, em);
      eval($sformatf("rnd%0d", n), o, eh, ew, em, m_err);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
